// File: rtl/serdes_pkg.sv
// Shared types and defaults for the serializer / deserializer pair.
package serdes_pkg;

    // Default word width, shared by both ends of the serial link.
    localparam int DEFAULT_DATA_WIDTH = 8;

    // Serializer control states: line idle, or shifting word bits out.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/word_hold_register.sv
// One-word holding register in front of the serializer's shifter.
// A word is taken from upstream whenever the register is empty. The shifter
// FSM empties it with the take strobe when it loads the word.
module word_hold_register #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    input  logic                  take,
    output logic [DATA_WIDTH-1:0] hold_data,
    output logic                  hold_valid,
    output logic                  ready
);

    logic [DATA_WIDTH-1:0] hold_data_reg;
    logic                  hold_valid_reg;

    // Capture a word when empty. Take and accept never coincide, because
    // take needs a full register and accept needs an empty one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_data_reg  <= '0;
            hold_valid_reg <= 1'b0;
        end else if (take) begin
            hold_valid_reg <= 1'b0;
        end else if (word_valid && !hold_valid_reg) begin
            hold_data_reg  <= word_data;
            hold_valid_reg <= 1'b1;
        end
    end

    assign hold_data  = hold_data_reg;
    assign hold_valid = hold_valid_reg;
    // Ready comes straight from the flop, so there is no combinational path from valid.
    assign ready      = !hold_valid_reg;

endmodule

// File: rtl/parallel_to_serial_converter.sv
// Parallel-to-serial converter: shifts words out LSB first, one bit per
// clock. The holding register lets the next word follow the last bit of the
// current one with no idle bit in between.
module parallel_to_serial_converter
    import serdes_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] parallelDataIn,
    input  logic                  dataValid,
    output logic                  dataReady,
    output logic                  serialDataOut,
    output logic                  frameStart,
    output logic                  busy
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    generate
        if (DATA_WIDTH < 2) begin : g_width_check
            $error("parallel_to_serial_converter: DATA_WIDTH must be >= 2");
        end
    endgenerate

    ser_state_t            state_reg, state_next;
    logic [DATA_WIDTH-1:0] shifter_reg, shifter_next;
    logic [CW-1:0]         bit_count_reg, bit_count_next;
    logic                  frame_start_reg, frame_start_next;

    logic                  take;
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  hold_valid;

    word_hold_register #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_hold (
        .clk       (clk),
        .reset     (reset),
        .word_data (parallelDataIn),
        .word_valid(dataValid),
        .take      (take),
        .hold_data (hold_data),
        .hold_valid(hold_valid),
        .ready     (dataReady)
    );

    // Next-state logic: load from hold when free, shift, or go back to idle.
    always_comb begin
        state_next       = state_reg;
        shifter_next     = shifter_reg;
        bit_count_next   = bit_count_reg;
        frame_start_next = 1'b0;
        take             = 1'b0;
        case (state_reg)
            IDLE: begin
                if (hold_valid) begin
                    take             = 1'b1;
                    shifter_next     = hold_data;
                    bit_count_next   = '0;
                    frame_start_next = 1'b1;
                    state_next       = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_count_reg != LAST_BIT) begin
                    shifter_next   = shifter_reg >> 1;
                    bit_count_next = bit_count_reg + 1'b1;
                end else if (hold_valid) begin
                    // Last bit is on the line and the next word is waiting:
                    // reload so the next word follows with no gap.
                    take             = 1'b1;
                    shifter_next     = hold_data;
                    bit_count_next   = '0;
                    frame_start_next = 1'b1;
                end else begin
                    // Clearing the shifter keeps the idle line at 0.
                    state_next     = IDLE;
                    shifter_next   = '0;
                    bit_count_next = '0;
                end
            end
            default: begin
                state_next     = IDLE;
                shifter_next   = '0;
                bit_count_next = '0;
            end
        endcase
    end

    // State, shifter, bit counter and frame marker registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            shifter_reg     <= '0;
            bit_count_reg   <= '0;
            frame_start_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            shifter_reg     <= shifter_next;
            bit_count_reg   <= bit_count_next;
            frame_start_reg <= frame_start_next;
        end
    end

    assign serialDataOut = shifter_reg[0];
    assign frameStart    = frame_start_reg;
    assign busy          = (state_reg == SHIFT);

endmodule
